lane_pipe_skid: RTL and testbench
=================================

Name: lane_pipe_skid

Overview:
- Parametrised multi-lane retiming pipeline for the PCIe physical-layer lane path (byte-striping / demux outputs). It replaces fixed 4-in/4-out flip-flop banks.
- Carries LANES lanes of DW-bit data plus a per-lane valid bit through STAGES register slices.
- Adds group valid/ready backpressure with registered ready, a synchronous flush, and an occupancy counter.
- Sits between the lane demux and the per-lane scrambler/encoder.

Parameters:
- LANES, 4, number of lanes moved in lockstep (1..16)
- DW, 8, data bits per lane
- STAGES, 2, number of skid slices in series (1..4); capacity is 2*STAGES beats
- OCW, $clog2(2*STAGES+1), occupancy counter width (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low
- flush  in  1  synchronous clear of all buffered beats, active-high
- in_data  in  LANES*DW  lane k occupies bits [k*DW +: DW]
- in_valid  in  LANES  per-lane valid mask of the offered beat
- in_ready  out  1  pipeline accepts a beat this cycle
- out_data  out  LANES*DW  head beat data
- out_valid  out  LANES  head beat lane mask; all zero when empty
- out_ready  in  1  downstream consumes head beat
- occupancy  out  OCW  number of beats held (0..2*STAGES)

Behaviour:
- Beat definition:
  - A beat is offered when |in_valid.
  - A beat is accepted when |in_valid && in_ready.
  - An offer with in_valid == 0 is a bubble: never stored, never counted.
- Beat contents: data and mask travel together, unmodified. Lanes with a 0 mask bit still carry their data bits.
- Output side:
  - Head beat is present when out_valid != 0.
  - It pops when |out_valid && out_ready.
  - out_ready while empty has no effect.
- Slice structure: each slice has a main register and a skid register, each with a full flag.
  - upstream ready_o = !skid_full, registered.
  - Accept while main empty, or while main is full and popping this cycle: the beat loads main.
  - Accept while main is full and not popping: the beat loads skid.
  - Pop with skid full: skid moves to main, skid empties.
  - Accept and pop in the same cycle: full throughput; no bubble inserted.
- Chaining: slice i output feeds slice i+1 input. in_ready = reset && slice0.ready_o. Output is taken from the last slice main register.
- Latency: an accepted beat appears at the output STAGES cycles later when unstalled. Sustained throughput is 1 beat/cycle.
- Backpressure and full condition:
  - With out_ready held 0, the block absorbs exactly 2*STAGES beats.
  - in_ready falls the cycle after the last slot fills. No beat is lost or duplicated.
- Ready timing: in_ready and out_valid depend only on registers (plus reset gating on in_ready). There is no combinational out_ready->in_ready path.
- Occupancy:
  - +1 on accept only, -1 on pop only, unchanged on both or neither.
  - Never exceeds 2*STAGES and never underflows.
- Flush:
  - At the edge where flush=1, all full flags clear and occupancy goes to 0.
  - A beat offered in that cycle is dropped; in_ready is forced 0 while flush=1.
  - A pop in the flush cycle is still reported to downstream as consumed.
  - The first accept is possible in the cycle after flush deasserts.
- Reset (reset=0 at edge):
  - All full flags 0, out_valid 0, out_data 0, occupancy 0.
  - Internal data registers cleared to 0.
  - in_ready is 0 while reset=0 and 1 in the first cycle after release.
  - Reset mid-operation discards all beats and takes priority over flush.

Decomposition:
- Shared package lane_pipe_pkg holds:
  - lane data beat typedef (packed mask + LANES*DW data)
  - MAX_STAGES=4
  - function computing OCW
- One sub-module, lane_skid_slice: a 2-entry skid register parametrised by beat width LANES*(DW+1). The top instantiates STAGES of them via generate, plus the occupancy counter and flush/reset gating.

Test Plan (LANES=4, DW=8, STAGES=2 unless noted):
1. Streaming: out_ready=1; offer beats 0x03020100/mask 0xF through 0x0B0A0908/mask 0xF on consecutive cycles. Each beat emerges 2 cycles after acceptance, 1 per cycle, occupancy steady at 2.
2. Backpressure: out_ready=0; offer 6 beats with data 0x11..0x66 replicated on all lanes. The first 4 beats are accepted and in_ready drops after the 4th, occupancy=4. Raise out_ready: outputs appear in order 0x11,0x22,0x33,0x44, then 0x55,0x66 are accepted.
3. Partial masks and bubbles: offer mask 0x5 data 0xDDCCBBAA, then in_valid=0, then mask 0x8 data 0x44332211. The output shows two beats with masks 0x5 and 0x8 and unchanged data; the bubble never appears and occupancy peaks at 2.
4. Flush: fill to occupancy 3, pulse flush while offering beat 0x77. Next cycle out_valid=0, occupancy=0, 0x77 never emerges; a beat 0x88 offered in the following cycle emerges 2 cycles after acceptance.
5. Reset mid-stream: with occupancy 4, drive reset=0 for one cycle. out_valid=0, out_data=0, occupancy=0, and in_ready=0 during reset; in_ready=1 the first cycle after release.
6. Random soak, STAGES=1 and STAGES=4: random in_valid/out_ready over 10000 cycles against a scoreboard queue. Check order, no loss or duplication, occupancy equal to queue depth, and in_ready never asserted while the queue holds 2*STAGES beats.

Source files
------------

// File: rtl/lane_pipe_pkg.sv
// Shared types and helpers for the multi-lane skid pipeline.
// The beat typedef describes the default 4-lane, 8-bit configuration.
package lane_pipe_pkg;

    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_DW     = 8;

    typedef struct packed {
        logic [DEF_LANES-1:0]        mask;
        logic [DEF_LANES*DEF_DW-1:0] data;
    } lane_beat_t;

    // Counter must represent 0..2*stages inclusive.
    function automatic int unsigned calc_ocw(input int unsigned stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/lane_skid_slice.sv
// Two-entry skid register slice: main register feeds downstream, skid absorbs one
// beat while main is stalled. Upstream ready is purely registered (!skid_full).
module lane_skid_slice
    import lane_pipe_pkg::*;
#(
    parameter int unsigned W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_full_q;
    logic         skid_full_q;
    logic         accept;
    logic         pop;

    assign up_ready = !skid_full_q;
    assign accept   = up_valid && !skid_full_q;
    assign pop      = main_full_q && dn_ready;
    assign dn_data  = main_q;
    assign dn_valid = main_full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_full_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (flush) begin
            main_full_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (pop && skid_full_q) begin
            // Skid full implies up_ready is low, so no accept can coincide.
            main_q      <= skid_q;
            skid_full_q <= 1'b0;
        end else if (accept && (!main_full_q || pop)) begin
            main_q      <= up_data;
            main_full_q <= 1'b1;
        end else if (accept) begin
            skid_q      <= up_data;
            skid_full_q <= 1'b1;
        end else if (pop) begin
            main_full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_pipe_skid.sv
// Multi-lane retiming pipeline: STAGES skid slices in series carrying lane data plus
// lane mask, with group backpressure, synchronous flush and an occupancy counter.
module lane_pipe_skid
    import lane_pipe_pkg::*;
#(
    parameter  int unsigned LANES  = 4,
    parameter  int unsigned DW     = 8,
    parameter  int unsigned STAGES = 2,
    localparam int unsigned OCW    = calc_ocw(STAGES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES-1:0]    in_valid,
    output logic                in_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES-1:0]    out_valid,
    input  logic                out_ready,
    output logic [OCW-1:0]      occupancy
);

    localparam int unsigned BW = LANES * (DW + 1);

    logic [BW-1:0] link_data  [STAGES+1];
    logic          link_valid [STAGES+1];
    logic          link_ready [STAGES+1];
    logic          accept;
    logic          pop;
    logic [OCW-1:0] occ_q;

    // Beat layout: mask in the top LANES bits, lane data below.
    assign link_data[0]       = {in_valid, in_data};
    assign link_valid[0]      = |in_valid;
    assign link_ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        lane_skid_slice #(
            .W (BW)
        ) u_slice (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_data  (link_data[i]),
            .up_valid (link_valid[i]),
            .up_ready (link_ready[i]),
            .dn_data  (link_data[i+1]),
            .dn_valid (link_valid[i+1]),
            .dn_ready (link_ready[i+1])
        );
    end

    assign in_ready  = reset && !flush && link_ready[0];
    assign out_data  = link_data[STAGES][LANES*DW-1:0];
    assign out_valid = link_valid[STAGES] ? link_data[STAGES][BW-1 -: LANES] : '0;

    assign accept = (|in_valid) && in_ready;
    assign pop    = link_valid[STAGES] && out_ready;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            occ_q <= '0;
        end else if (accept && !pop) begin
            occ_q <= occ_q + OCW'(1);
        end else if (pop && !accept) begin
            occ_q <= occ_q - OCW'(1);
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_lane_pipe_skid.sv
// Bench for lane_pipe_skid: directed scenarios on a STAGES=2 instance and a random
// soak of STAGES=1/2/4 instances against per-instance FIFO scoreboards.
module tb_lane_pipe_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_valid;

    logic [31:0] od [3];
    logic [3:0]  ov [3];
    logic        ir [3];
    logic [3:0]  oc [3];
    logic [1:0]  occ_s1;
    logic [2:0]  occ_s2;
    logic [3:0]  occ_s4;

    int errors = 0;
    int checks = 0;
    int cap [3] = '{2, 4, 8};
    logic [35:0] sbq [3][$];

    always #5 clk = ~clk;

    assign oc[0] = {2'b00, occ_s1};
    assign oc[1] = {1'b0, occ_s2};
    assign oc[2] = occ_s4;

    lane_pipe_skid #(.LANES(4), .DW(8), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .occupancy(occ_s1)
    );

    lane_pipe_skid #(.LANES(4), .DW(8), .STAGES(2)) u_s2 (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .occupancy(occ_s2)
    );

    lane_pipe_skid #(.LANES(4), .DW(8), .STAGES(4)) u_s4 (
        .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .occupancy(occ_s4)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stream_beat(input int k);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'(4 * k + l);
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; in_valid = 4'h0; in_data = 32'h0; out_ready = 1'b0;
        cyc; cyc;
        checks++; if (ov[1] !== 4'h0) begin errors++;
            $display("FAIL reset_out_valid: got %h want 0", ov[1]); end
        checks++; if (od[1] !== 32'h0) begin errors++;
            $display("FAIL reset_out_data: got %h want 0", od[1]); end
        checks++; if (oc[1] !== 4'd0) begin errors++;
            $display("FAIL reset_occupancy: got %0d want 0", oc[1]); end
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", ir[1]); end
        reset = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++;
            $display("FAIL reset_release_ready: got %b want 1", ir[1]); end
    endtask

    task automatic test_stream;
        logic [3:0] exp_occ;
        int j;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = 4'hF;
                in_data  = stream_beat(c);
            end else begin
                in_valid = 4'h0;
            end
            #1;
            if (c < 3) begin
                checks++; if (ir[1] !== 1'b1) begin errors++;
                    $display("FAIL stream_in_ready c=%0d: got %b want 1", c, ir[1]); end
            end
            cyc;
            // Accepted so far minus popped so far (a beat pops the cycle after it shows).
            exp_occ = 4'((c + 1 < 3 ? c + 1 : 3) - (c - 1 > 0 ? (c - 1 < 3 ? c - 1 : 3) : 0));
            checks++; if (oc[1] !== exp_occ) begin errors++;
                $display("FAIL stream_occ c=%0d: got %0d want %0d", c, oc[1], exp_occ); end
            j = c - 1;
            if (j >= 0 && j < 3) begin
                checks++; if ({ov[1], od[1]} !== {4'hF, stream_beat(j)}) begin errors++;
                    $display("FAIL stream_out c=%0d: got %h/%h want F/%h", c, ov[1], od[1],
                             stream_beat(j)); end
            end else begin
                checks++; if (ov[1] !== 4'h0) begin errors++;
                    $display("FAIL stream_idle c=%0d: got %h want 0", c, ov[1]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int nacc;
        int nout;
        out_ready = 1'b0; in_valid = 4'h0;
        cyc;
        for (int c = 0; c < 4; c++) begin
            in_valid = 4'hF; in_data = {4{8'(17 * (c + 1))}};
            #1;
            checks++; if (ir[1] !== 1'b1) begin errors++;
                $display("FAIL bp_accept c=%0d: got %b want 1", c, ir[1]); end
            cyc;
        end
        in_data = 32'h5555_5555;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL bp_full_ready: got %b want 0", ir[1]); end
        checks++; if (oc[1] !== 4'd4) begin errors++;
            $display("FAIL bp_full_occ: got %0d want 4", oc[1]); end
        checks++; if ({ov[1], od[1]} !== {4'hF, 32'h1111_1111}) begin errors++;
            $display("FAIL bp_head: got %h/%h want F/11111111", ov[1], od[1]); end
        cyc;
        out_ready = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL bp_no_comb_path: got %b want 0", ir[1]); end
        nacc = 4; nout = 0;
        for (int t = 0; t < 30 && nout < 6; t++) begin
            in_valid = (nacc < 6) ? 4'hF : 4'h0;
            in_data  = {4{8'(17 * (nacc + 1))}};
            #1;
            if (ov[1] !== 4'h0) begin
                checks++;
                if ({ov[1], od[1]} !== {4'hF, {4{8'(17 * (nout + 1))}}}) begin errors++;
                    $display("FAIL bp_order n=%0d: got %h/%h want F/%h", nout, ov[1], od[1],
                             {4{8'(17 * (nout + 1))}}); end
                nout++;
            end
            if (in_valid != 4'h0 && ir[1] === 1'b1) nacc++;
            cyc;
        end
        checks++; if (nout != 6) begin errors++;
            $display("FAIL bp_drain_count: got %0d want 6", nout); end
        checks++; if (nacc != 6) begin errors++;
            $display("FAIL bp_accept_count: got %0d want 6", nacc); end
    endtask

    task automatic test_partial;
        logic [3:0]  mk [3] = '{4'h5, 4'h0, 4'h8};
        logic [31:0] dt [3] = '{32'hDDCC_BBAA, 32'hFFFF_FFFF, 32'h4433_2211};
        int peak;
        int nout;
        out_ready = 1'b0; in_valid = 4'h0;
        cyc;
        peak = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = mk[k]; in_data = dt[k];
            #1;
            if (mk[k] != 4'h0) begin
                checks++; if (ir[1] !== 1'b1) begin errors++;
                    $display("FAIL partial_ready k=%0d: got %b want 1", k, ir[1]); end
            end
            cyc;
            if (int'(oc[1]) > peak) peak = int'(oc[1]);
        end
        in_valid = 4'h0; out_ready = 1'b1; nout = 0;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (ov[1] !== 4'h0) begin
                checks++;
                if (nout == 0 && {ov[1], od[1]} !== {mk[0], dt[0]}) begin errors++;
                    $display("FAIL partial_beat0: got %h/%h want 5/%h", ov[1], od[1], dt[0]);
                end else if (nout == 1 && {ov[1], od[1]} !== {mk[2], dt[2]}) begin errors++;
                    $display("FAIL partial_beat1: got %h/%h want 8/%h", ov[1], od[1], dt[2]);
                end else if (nout > 1) begin errors++;
                    $display("FAIL partial_extra: got %h/%h want none", ov[1], od[1]);
                end
                nout++;
            end
            cyc;
            if (int'(oc[1]) > peak) peak = int'(oc[1]);
        end
        checks++; if (nout != 2) begin errors++;
            $display("FAIL partial_count: got %0d want 2", nout); end
        checks++; if (peak != 2) begin errors++;
            $display("FAIL partial_peak: got %0d want 2", peak); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'hF; in_data = {4{8'(8'hA1 + c)}};
            #1;
            checks++; if (ir[1] !== 1'b1) begin errors++;
                $display("FAIL flush_fill c=%0d: got %b want 1", c, ir[1]); end
            cyc;
        end
        in_valid = 4'h0;
        checks++; if (oc[1] !== 4'd3) begin errors++;
            $display("FAIL flush_fill_occ: got %0d want 3", oc[1]); end
        flush = 1'b1; in_valid = 4'hF; in_data = 32'h7777_7777;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL flush_ready: got %b want 0", ir[1]); end
        cyc;
        flush = 1'b0; in_valid = 4'h0;
        checks++; if (ov[1] !== 4'h0) begin errors++;
            $display("FAIL flush_out_valid: got %h want 0", ov[1]); end
        checks++; if (oc[1] !== 4'd0) begin errors++;
            $display("FAIL flush_occ: got %0d want 0", oc[1]); end
        in_valid = 4'hF; in_data = 32'h8888_8888;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++;
            $display("FAIL flush_reaccept: got %b want 1", ir[1]); end
        cyc;
        in_valid = 4'h0; out_ready = 1'b1;
        checks++; if (ov[1] !== 4'h0 || oc[1] !== 4'd1) begin errors++;
            $display("FAIL flush_lat1: got %h occ %0d want 0 occ 1", ov[1], oc[1]); end
        cyc;
        checks++; if ({ov[1], od[1]} !== {4'hF, 32'h8888_8888}) begin errors++;
            $display("FAIL flush_post_beat: got %h/%h want F/88888888", ov[1], od[1]); end
        for (int t = 0; t < 4; t++) begin
            cyc;
            checks++; if (ov[1] !== 4'h0) begin errors++;
                $display("FAIL flush_ghost t=%0d: got %h/%h want 0", t, ov[1], od[1]); end
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 4'hF; in_data = {4{8'(8'hC0 + c)}};
            #1;
            checks++; if (ir[1] !== 1'b1) begin errors++;
                $display("FAIL rmid_fill c=%0d: got %b want 1", c, ir[1]); end
            cyc;
        end
        checks++; if (oc[1] !== 4'd4) begin errors++;
            $display("FAIL rmid_occ_full: got %0d want 4", oc[1]); end
        reset = 1'b0; in_valid = 4'hF; in_data = 32'hEEEE_EEEE; out_ready = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL rmid_ready_in_reset: got %b want 0", ir[1]); end
        cyc;
        checks++; if (ov[1] !== 4'h0 || od[1] !== 32'h0) begin errors++;
            $display("FAIL rmid_out: got %h/%h want 0/0", ov[1], od[1]); end
        checks++; if (oc[1] !== 4'd0) begin errors++;
            $display("FAIL rmid_occ: got %0d want 0", oc[1]); end
        checks++; if (ir[1] !== 1'b0) begin errors++;
            $display("FAIL rmid_ready_held: got %b want 0", ir[1]); end
        reset = 1'b1; in_valid = 4'h0;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++;
            $display("FAIL rmid_ready_release: got %b want 1", ir[1]); end
        cyc;
    endtask

    task automatic test_soak;
        int npop [3];
        int pr;
        reset = 1'b0; flush = 1'b0; in_valid = 4'h0; out_ready = 1'b0;
        cyc;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sbq[i].delete();
            npop[i] = 0;
        end
        pr = 50;
        for (int n = 0; n < 10000; n++) begin
            if (n % 500 == 0) pr = (n / 500 % 3 == 0) ? 15 : ((n / 500 % 3 == 1) ? 50 : 90);
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < pr);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++; if (int'(oc[i]) != sbq[i].size()) begin errors++;
                    $display("FAIL soak_occ inst=%0d n=%0d: got %0d want %0d", i, n, oc[i],
                             sbq[i].size()); end
                checks++; if (ir[i] === 1'b1 && (sbq[i].size() >= cap[i] || flush)) begin
                    errors++;
                    $display("FAIL soak_ready inst=%0d n=%0d: got 1 want 0 (depth %0d)", i, n,
                             sbq[i].size()); end
                if (ov[i] !== 4'h0) begin
                    checks++;
                    if (sbq[i].size() == 0) begin errors++;
                        $display("FAIL soak_dup inst=%0d n=%0d: got %h/%h want empty", i, n,
                                 ov[i], od[i]);
                    end else if ({ov[i], od[i]} !== sbq[i][0]) begin errors++;
                        $display("FAIL soak_order inst=%0d n=%0d: got %h/%h want %h", i, n,
                                 ov[i], od[i], sbq[i][0]);
                    end
                    if (out_ready && sbq[i].size() != 0) begin
                        void'(sbq[i].pop_front());
                        npop[i]++;
                    end
                end
                if (in_valid != 4'h0 && ir[i] === 1'b1) sbq[i].push_back({in_valid, in_data});
                if (flush) sbq[i].delete();
            end
            cyc;
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (npop[i] < 1000) begin errors++;
                $display("FAIL soak_progress inst=%0d: got %0d pops want >=1000", i, npop[i]);
            end
        end
        flush = 1'b0; in_valid = 4'h0;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_partial;
        test_flush;
        test_reset_mid;
        test_soak;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
